// File: rtl/seg7_pkg.sv
// Shared encodings for the seven-segment capture path.
// Segment patterns are active-low in {a,b,c,d,e,f,g} order, with a in bit 6.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam bcd_t BCD_BLANK = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low segment pattern to BCD.
// A pattern outside the digit and blank set is flagged with valid=0.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output bcd_t       bcd
);

  always_comb begin
    valid = 1'b1;
    bcd   = '0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers digit values from a multiplexed 7-segment bus and hands out
// complete frames over valid/ready, counting undecodable stable patterns.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int ERR_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     an_n,
  output logic [4*NDIG-1:0]   frame_data,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [ERR_W-1:0]    err_cnt,
  input  logic                err_clr
);

  localparam int            CW        = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] STAB_MAX  = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] STAB_FIRE = CW'(STABLE_CYC - 2);

  logic [6:0]             seg_s1_q, seg_s2_q, seg_p_q;
  logic [NDIG-1:0]        an_s1_q, an_s2_q, an_p_q;
  logic [CW-1:0]          stab_cnt_q, stab_cnt_d;
  bcd_t [NDIG-1:0]        digit_q, digit_d;
  logic [NDIG-1:0]        seen_q, seen_d;
  logic [4*NDIG-1:0]      frame_data_q, frame_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;

  logic                   same;
  logic                   commit;
  logic                   load;
  logic                   dec_valid;
  bcd_t                   dec_bcd;

  seg7_to_bcd u_dec (
    .seg   (seg_s2_q),
    .valid (dec_valid),
    .bcd   (dec_bcd)
  );

  // The *_p stage holds the previous synced pair for the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= 7'h7F;
      seg_s2_q <= 7'h7F;
      seg_p_q  <= 7'h7F;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      an_p_q   <= '1;
    end else begin
      seg_s1_q <= seg_n;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      an_s1_q  <= an_n;
      an_s2_q  <= an_s1_q;
      an_p_q   <= an_s2_q;
    end
  end

  always_comb begin
    same   = $onehot(~an_s2_q) && (an_s2_q == an_p_q) && (seg_s2_q == seg_p_q);
    commit = same && (stab_cnt_q == STAB_FIRE);
    load   = (&seen_q) && (!frame_valid_q || frame_ready);

    stab_cnt_d = '0;
    if (same) stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 1'b1;

    digit_d = digit_q;
    seen_d  = load ? '0 : seen_q;
    for (int i = 0; i < NDIG; i++) begin
      if (commit && dec_valid && !an_s2_q[i]) begin
        digit_d[i] = dec_bcd;
        seen_d[i]  = 1'b1;
      end
    end

    // Frame takes the digits as registered, so a same-cycle commit lands in the next frame.
    frame_data_d  = load ? digit_q : frame_data_q;
    frame_valid_d = load ? 1'b1 : (frame_valid_q && !frame_ready);

    err_cnt_d = err_cnt_q;
    if (err_clr)                                        err_cnt_d = '0;
    else if (commit && !dec_valid && err_cnt_q != '1)   err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_q    <= '0;
      digit_q       <= '0;
      seen_q        <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      stab_cnt_q    <= stab_cnt_d;
      digit_q       <= digit_d;
      seen_q        <= seen_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign err_cnt     = err_cnt_q;

endmodule
